// File: rtl/inst_fetcher_pkg.sv
// Shared widths, fetch FSM encodings and address helper for the instruction fetcher.
// Imported by inst_fetcher and inst_word_assembler.
package inst_fetcher_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam int unsigned ByteBus     = 8;

    localparam logic [InstBus-1:0] ZeroWord = '0;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FetchIdle   = 2'd0;
    localparam fetch_state_t FetchLookup = 2'd1;
    localparam fetch_state_t FetchMem    = 2'd2;
    localparam fetch_state_t FetchFill   = 2'd3;

    // Byte address within the fetched word; wraps modulo 2^32.
    function automatic logic [InstAddrBus-1:0] byte_addr(input logic [InstAddrBus-1:0] base,
                                                         input logic [2:0] offset);
        return base + {{(InstAddrBus - 3){1'b0}}, offset};
    endfunction

endpackage

// File: rtl/inst_word_assembler.sv
// Collects four little-endian bytes from the memory port into one instruction word.
// A byte is present the cycle after its grant; done flags the fourth capture.
module inst_word_assembler
    import inst_fetcher_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               grant_i,
    input  logic               capture_i,
    input  logic [ByteBus-1:0] byte_i,
    output logic               granted_d_o,
    output logic [InstBus-1:0] word_o,
    output logic               done_o
);

    logic               granted_d_q;
    logic [2:0]         rcv_cnt_q;
    logic [InstBus-1:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            granted_d_q <= 1'b0;
            rcv_cnt_q   <= 3'd0;
            word_q      <= ZeroWord;
        end else if (clear_i) begin
            granted_d_q <= 1'b0;
            rcv_cnt_q   <= 3'd0;
            word_q      <= ZeroWord;
        end else begin
            granted_d_q <= grant_i;
            if (granted_d_q && capture_i) begin
                word_q[{rcv_cnt_q[1:0], 3'b000} +: ByteBus] <= byte_i;
                rcv_cnt_q                                   <= rcv_cnt_q + 3'd1;
            end
        end
    end

    assign granted_d_o = granted_d_q;
    assign word_o      = word_q;
    // Fires while the last byte is on the bus so the word is complete in the next cycle.
    assign done_o      = granted_d_q && capture_i && (rcv_cnt_q == 3'd3);

endmodule

// File: rtl/inst_fetcher.sv
// Fetch-side initiator: queries the instruction cache, fills it byte-wise from memory on a miss.
// Define INST_CACHE_EN to enable the cache lookup/fill path; undefined skips LOOKUP.
module inst_fetcher
    import inst_fetcher_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_req_i,
    input  logic [InstAddrBus-1:0] if_pc_i,
    input  logic                   flush_i,
    output logic                   if_ready_o,
    output logic                   if_valid_o,
    output logic [InstBus-1:0]     if_inst_o,
    output logic                   cache_query_o,
    output logic [InstAddrBus-1:0] query_addr_o,
    input  logic                   inst_hit_i,
    input  logic [InstBus-1:0]     inst_cache_i,
    output logic                   cache_enable_o,
    output logic [InstAddrBus-1:0] inst_addr_o,
    output logic [InstBus-1:0]     inst_cache_o,
    output logic                   mem_req_o,
    output logic [InstAddrBus-1:0] mem_addr_o,
    input  logic                   mem_grant_i,
    input  logic [ByteBus-1:0]     mem_byte_i
);

`ifdef INST_CACHE_EN
    localparam fetch_state_t AcceptState = FetchLookup;
    logic unused_in;
    assign unused_in = ^if_pc_i[1:0];
`else
    localparam fetch_state_t AcceptState = FetchMem;
    logic unused_in;
    assign unused_in = ^{if_pc_i[1:0], inst_hit_i, inst_cache_i};
`endif

    fetch_state_t           state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [2:0]             issue_cnt_q, issue_cnt_d;
    logic                   absorb_q, absorb_d;
    logic                   valid_q, valid_d;
    logic [InstBus-1:0]     inst_q, inst_d;

    logic               asm_clear;
    logic               asm_capture;
    logic               mem_grant;
    logic               granted_d;
    logic               word_done;
    logic [InstBus-1:0] word;

    inst_word_assembler u_word_assembler (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (asm_clear),
        .grant_i     (mem_grant),
        .capture_i   (asm_capture),
        .byte_i      (mem_byte_i),
        .granted_d_o (granted_d),
        .word_o      (word),
        .done_o      (word_done)
    );

    // absorb_q is the single drain cycle after a flush that caught a byte in flight.
    assign mem_req_o   = (state_q == FetchMem) && !issue_cnt_q[2] && !absorb_q;
    assign mem_grant   = mem_req_o && mem_grant_i;
    assign asm_capture = (state_q == FetchMem) && !absorb_q;
    assign mem_addr_o  = mem_req_o ? byte_addr(pc_q, issue_cnt_q) : ZeroWord;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issue_cnt_d = issue_cnt_q;
        absorb_d    = 1'b0;
        valid_d     = 1'b0;
        inst_d      = ZeroWord;
        asm_clear   = 1'b0;
        case (state_q)
            FetchIdle: begin
                if (if_req_i && !flush_i) begin
                    pc_d        = {if_pc_i[InstAddrBus-1:2], 2'b00};
                    issue_cnt_d = 3'd0;
                    asm_clear   = 1'b1;
                    state_d     = AcceptState;
                end
            end
`ifdef INST_CACHE_EN
            FetchLookup: begin
                if (flush_i) begin
                    state_d = FetchIdle;
                end else if (inst_hit_i) begin
                    valid_d = 1'b1;
                    inst_d  = inst_cache_i;
                    state_d = FetchIdle;
                end else begin
                    issue_cnt_d = 3'd0;
                    asm_clear   = 1'b1;
                    state_d     = FetchMem;
                end
            end
`endif
            FetchMem: begin
                if (absorb_q) begin
                    state_d = FetchIdle;
                end else if (flush_i) begin
                    absorb_d = granted_d;
                    if (!granted_d) state_d = FetchIdle;
                end else begin
                    if (mem_grant) issue_cnt_d = issue_cnt_q + 3'd1;
                    if (word_done) state_d = FetchFill;
                end
            end
            FetchFill: begin
                valid_d = !flush_i;
                inst_d  = flush_i ? ZeroWord : word;
                state_d = FetchIdle;
            end
            default: state_d = FetchIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FetchIdle;
            pc_q        <= ZeroWord;
            issue_cnt_q <= 3'd0;
            absorb_q    <= 1'b0;
            valid_q     <= 1'b0;
            inst_q      <= ZeroWord;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issue_cnt_q <= issue_cnt_d;
            absorb_q    <= absorb_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
        end
    end

    assign if_ready_o = (state_q == FetchIdle);
    assign if_valid_o = valid_q;
    assign if_inst_o  = inst_q;

`ifdef INST_CACHE_EN
    assign cache_query_o  = (state_q == FetchLookup);
    assign cache_enable_o = (state_q == FetchFill);
`else
    assign cache_query_o  = 1'b0;
    assign cache_enable_o = 1'b0;
`endif
    assign query_addr_o = cache_query_o ? pc_q : ZeroWord;
    assign inst_addr_o  = cache_enable_o ? pc_q : ZeroWord;
    assign inst_cache_o = cache_enable_o ? word : ZeroWord;

endmodule
